// File: rtl/down_timer_if.sv
// down_timer_if: load/count/status bundle between a sequencer (master) and the down timer (slave).
interface down_timer_if #(parameter int WIDTH = 8);
  logic             load;
  logic [WIDTH-1:0] preset;
  logic             ce;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             done;
  logic             tc;
  modport master (output load, preset, ce, input out, busy, done, tc);
  modport slave  (input load, preset, ce, output out, busy, done, tc);
endinterface

// File: rtl/down_timer.sv
// down_timer: loadable down-counter with terminal-count borrow, busy level and one-cycle done pulse.
// Define DOWN_TIMER_AUTO_RELOAD_EN to reload the last preset at terminal count instead of stopping.
module down_timer #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  down_timer_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_e;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             done_q, done_d;
  logic             tc;
  assign tc       = (state_q == RUN) && bus.ce && (out_q == WIDTH'(1));
  assign bus.tc   = tc;
  assign bus.out  = out_q;
  assign bus.busy = (state_q == RUN);
  assign bus.done = done_q;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
  assign reload_d = (bus.load && bus.preset != '0) ? bus.preset : reload_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) reload_q <= '0;
    else       reload_q <= reload_d;
`endif
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    done_d  = 1'b0;
    if (bus.load) begin
      out_d   = bus.preset;
      state_d = (bus.preset != '0) ? RUN : IDLE;
    end else if (tc) begin
      done_d = 1'b1;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
      out_d  = reload_q;
`else
      out_d   = '0;
      state_d = IDLE;
`endif
    end else if (state_q == RUN && bus.ce) begin
      out_d = out_q - WIDTH'(1);
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
endmodule
